// File: rtl/imem_boot_loader_if.sv
// ----------------------------------------------------------------------------
// imem_boot_loader_if : program stream, imem write port and core control
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface imem_boot_loader_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
);
   logic                  start;
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_last;
   logic                  in_ready;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [DATA_WIDTH-1:0] imem_wdata;
   logic                  core_rst;
   logic                  done;
   logic                  error;
   logic [ADDR_WIDTH:0]   word_count;

   modport master (
      output start, in_valid, in_data, in_last,
      input  in_ready, imem_we, imem_addr, imem_wdata,
      input  core_rst, done, error, word_count
   );

   modport slave (
      input  start, in_valid, in_data, in_last,
      output in_ready, imem_we, imem_addr, imem_wdata,
      output core_rst, done, error, word_count
   );
endinterface

`default_nettype wire

// File: rtl/imem_boot_loader.sv
// ----------------------------------------------------------------------------
// imem_boot_loader : streams a program into instruction memory, holds core in reset
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module imem_boot_loader #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  wire logic        clk,
   input  wire logic        rst,
   imem_boot_loader_if.slave bus
);

   localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH:0] LAST_IDX = ((ADDR_WIDTH+1)'(1) << ADDR_WIDTH) - CNT_ONE;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_RELEASE = 3'd2,
      S_RUN     = 3'd3,
      S_ERR     = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic                  ready_q, ready_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  core_rst_q, core_rst_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  handshake;

   // ready_q is high exactly while in LOAD, so it doubles as the accept qualifier
   assign handshake = bus.in_valid & ready_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ready_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         core_rst_q <= 1'b1;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         core_rst_q <= core_rst_d;
         done_q     <= done_d;
         error_q    <= error_d;
         count_q    <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_LOAD;
               count_d = '0;
            end
         end
         S_LOAD: begin
            if (handshake) begin
               we_d    = 1'b1;
               addr_d  = count_q[ADDR_WIDTH-1:0];
               wdata_d = bus.in_data;
               count_d = count_q + CNT_ONE;
               // the word at the top address is still written before overflowing
               if (bus.in_last) begin
                  state_d = S_RELEASE;
               end else if (count_q == LAST_IDX) begin
                  state_d = S_ERR;
               end
            end
         end
         S_RELEASE: begin
            state_d = S_RUN;
         end
         S_RUN, S_ERR: begin
            if (bus.start) begin
               state_d = S_LOAD;
               count_d = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      ready_d    = (state_d == S_LOAD);
      core_rst_d = (state_d != S_RUN);
      done_d     = (state_d == S_RUN);
      error_d    = (state_d == S_ERR);
   end

   assign bus.in_ready   = ready_q;
   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign bus.core_rst   = core_rst_q;
   assign bus.done       = done_q;
   assign bus.error      = error_q;
   assign bus.word_count = count_q;

endmodule

`default_nettype wire
